// File: rtl/timer_nbit_pwm_pkg.sv
// Shared definitions for the N-bit PWM timer family: waveform modes, clock
// select codes, control/flag register bit positions and small helpers.
package timer_nbit_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_PC     = 2'b01,
    MODE_CTC    = 2'b10,
    MODE_FAST   = 2'b11
  } mode_e;

  localparam logic [2:0] CS_STOP     = 3'd0;
  localparam logic [2:0] CS_DIV1     = 3'd1;
  localparam logic [2:0] CS_DIV8     = 3'd2;
  localparam logic [2:0] CS_DIV64    = 3'd3;
  localparam logic [2:0] CS_DIV256   = 3'd4;
  localparam logic [2:0] CS_DIV1024  = 3'd5;
  localparam logic [2:0] CS_EXT_FALL = 3'd6;
  localparam logic [2:0] CS_EXT_RISE = 3'd7;

  localparam int TCCR_FOC    = 7;
  localparam int TCCR_WGM0   = 6;
  localparam int TCCR_COM_HI = 5;
  localparam int TCCR_COM_LO = 4;
  localparam int TCCR_WGM1   = 3;
  localparam int TIMSK_TOIE  = 0;
  localparam int TIMSK_OCIE  = 1;
  localparam int TIFR_TOV    = 0;
  localparam int TIFR_OCF    = 1;

  localparam logic [1:0] COM_OFF    = 2'b00;
  localparam logic [1:0] COM_TOGGLE = 2'b01;
  localparam logic [1:0] COM_CLEAR  = 2'b10;
  localparam logic [1:0] COM_SET    = 2'b11;

  // Waveform mode encoded in a TCCR value.
  function automatic mode_e mode_of(input logic [7:0] tccr);
    return mode_e'({tccr[TCCR_WGM1], tccr[TCCR_WGM0]});
  endfunction

  // PWM modes double-buffer OCR and ignore FOC.
  function automatic logic is_pwm(input mode_e m);
    return (m == MODE_PC) || (m == MODE_FAST);
  endfunction

  // Output-compare pin action for normal/CTC modes on a match or forced compare.
  function automatic logic oc_match_action(input logic [1:0] com, input logic oc);
    logic res;
    case (com)
      COM_OFF:    res = 1'b0;
      COM_TOGGLE: res = ~oc;
      COM_CLEAR:  res = 1'b0;
      COM_SET:    res = 1'b1;
      default:    res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/timer_nbit_pwm_prescaler.sv
// Clock prescaler for the timer family: divides sysClock by 1/8/64/256/1024
// or detects edges on the external count pin, producing a one-cycle tick.
module timer_prescaler
  import timer_nbit_pwm_pkg::*;
#(
  parameter int PRE_W = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] cs,
  input  logic       t_in,
  output logic       tick
);

  logic [PRE_W-1:0] pre_r;
  logic [PRE_W-1:0] div_mask_s;
  logic [1:0]       sync_r;
  logic             prev_r;
  logic             run_s;

  // Divider only runs for the internal divide-by settings; otherwise held at zero.
  assign run_s = (cs >= CS_DIV1) && (cs <= CS_DIV1024);

  // Free-running prescaler counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r <= '0;
    end else if (run_s) begin
      pre_r <= pre_r + PRE_W'(1);
    end else begin
      pre_r <= '0;
    end
  end

  // Two-flop synchroniser plus previous-value flop for edge detection on T_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], t_in};
      prev_r <= sync_r[1];
    end
  end

  // Tick selection: divider terminal count or synchronised pin edge.
  always_comb begin
    div_mask_s = '0;
    tick       = 1'b0;
    case (cs)
      CS_STOP:     tick = 1'b0;
      CS_DIV1:     tick = 1'b1;
      CS_DIV8: begin
        div_mask_s = PRE_W'(7);
        tick       = ((pre_r & div_mask_s) == div_mask_s);
      end
      CS_DIV64: begin
        div_mask_s = PRE_W'(63);
        tick       = ((pre_r & div_mask_s) == div_mask_s);
      end
      CS_DIV256: begin
        div_mask_s = PRE_W'(255);
        tick       = ((pre_r & div_mask_s) == div_mask_s);
      end
      CS_DIV1024: begin
        div_mask_s = PRE_W'(1023);
        tick       = ((pre_r & div_mask_s) == div_mask_s);
      end
      CS_EXT_FALL: tick = prev_r & ~sync_r[1];
      CS_EXT_RISE: tick = sync_r[1] & ~prev_r;
      default:     tick = 1'b0;
    endcase
  end

endmodule

// File: rtl/timer_nbit_pwm.sv
// WIDTH-bit timer/counter with prescaler, four waveform modes, double-buffered
// compare register, compare output pin and overflow/compare interrupt requests.
module timer_nbit_pwm
  import timer_nbit_pwm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 10
) (
  input  logic             sysClock,
  input  logic             rst_n,
  input  logic             T_in,
  input  logic [WIDTH-1:0] TCNT_data,
  input  logic [WIDTH-1:0] OCR_input,
  input  logic [7:0]       TCCR_input,
  input  logic [7:0]       TIMSK_input,
  input  logic [7:0]       TIFR_input,
  input  logic             TCNT_write_enable,
  input  logic             OCR_write_enable,
  input  logic             TCCR_write_enable,
  input  logic             TIMSK_write_enable,
  input  logic             TIFR_write_enable,
  input  logic             clear_count,
  output logic [WIDTH-1:0] TCNT_output,
  output logic [WIDTH-1:0] OCR_output,
  output logic [7:0]       TCCR_output,
  output logic [7:0]       TIMSK_output,
  output logic [7:0]       TIFR_output,
  output logic             OC_out,
  output logic             irq_ovf,
  output logic             irq_cmp
);

  localparam logic [WIDTH-1:0] MAX_V  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] tcnt_r, ocr_buf_r, ocr_act_r;
  logic [7:0]       tccr_r, timsk_r, tifr_r;
  logic             oc_r, dir_down_r;

  logic [WIDTH-1:0] tcnt_nxt_s, ocr_buf_nxt_s, ocr_act_nxt_s;
  logic [7:0]       tccr_nxt_s, timsk_nxt_s, tifr_nxt_s;
  logic             oc_nxt_s, dir_down_nxt_s;

  logic             tick_s, cnt_tick_s, match_s, at_max_s, at_zero_s;
  logic             tov_set_s, foc_s, pc_down_s;
  logic [1:0]       com_s;
  mode_e            mode_s;

  timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk   (sysClock),
    .rst_n (rst_n),
    .cs    (tccr_r[2:0]),
    .t_in  (T_in),
    .tick  (tick_s)
  );

  assign mode_s     = mode_of(tccr_r);
  assign com_s      = tccr_r[TCCR_COM_HI:TCCR_COM_LO];
  assign at_max_s   = (tcnt_r == MAX_V);
  assign at_zero_s  = (tcnt_r == ZERO_V);
  // A counter write or clear owns the cycle: no counting and no compare match.
  assign cnt_tick_s = tick_s & ~clear_count & ~TCNT_write_enable;
  assign match_s    = cnt_tick_s & (tcnt_r == ocr_act_r);
  // FOC only acts when both the current and the written mode are non-PWM.
  assign foc_s      = TCCR_write_enable & TCCR_input[TCCR_FOC]
                      & ~is_pwm(mode_of(TCCR_input)) & ~is_pwm(mode_s);
  // Direction the phase-correct counter is heading after this tick; a match
  // at the turning points belongs to the new direction.
  assign pc_down_s  = at_max_s ? 1'b1 : (at_zero_s ? 1'b0 : dir_down_r);

  // Counter and direction next-state.
  always_comb begin
    tcnt_nxt_s     = tcnt_r;
    dir_down_nxt_s = dir_down_r;
    tov_set_s      = 1'b0;
    if (clear_count) begin
      tcnt_nxt_s = ZERO_V;
    end else if (TCNT_write_enable) begin
      tcnt_nxt_s = TCNT_data;
    end else if (cnt_tick_s) begin
      case (mode_s)
        MODE_CTC: begin
          if (match_s) begin
            tcnt_nxt_s = ZERO_V;
          end else if (at_max_s) begin
            tcnt_nxt_s = ZERO_V;
            tov_set_s  = 1'b1;
          end else begin
            tcnt_nxt_s = tcnt_r + ONE_V;
          end
        end
        MODE_PC: begin
          if (dir_down_r) begin
            if (at_zero_s) begin
              dir_down_nxt_s = 1'b0;
              tcnt_nxt_s     = ONE_V;
              tov_set_s      = 1'b1;
            end else begin
              tcnt_nxt_s = tcnt_r - ONE_V;
            end
          end else begin
            if (at_max_s) begin
              dir_down_nxt_s = 1'b1;
              tcnt_nxt_s     = MAX_V - ONE_V;
            end else begin
              tcnt_nxt_s = tcnt_r + ONE_V;
            end
          end
        end
        default: begin
          if (at_max_s) begin
            tcnt_nxt_s = ZERO_V;
            tov_set_s  = 1'b1;
          end else begin
            tcnt_nxt_s = tcnt_r + ONE_V;
          end
        end
      endcase
    end else begin
      tcnt_nxt_s = tcnt_r;
    end
    // A mode change keeps the count but always restarts counting upward.
    if (TCCR_write_enable && (mode_of(TCCR_input) != mode_s)) begin
      dir_down_nxt_s = 1'b0;
    end else begin
      dir_down_nxt_s = dir_down_nxt_s;
    end
  end

  // Compare register buffering and control/flag register next-state.
  always_comb begin
    ocr_buf_nxt_s = OCR_write_enable ? OCR_input : ocr_buf_r;
    ocr_act_nxt_s = ocr_act_r;
    if (is_pwm(mode_s)) begin
      if (cnt_tick_s && at_max_s) begin
        ocr_act_nxt_s = ocr_buf_r;
      end else begin
        ocr_act_nxt_s = ocr_act_r;
      end
    end else if (OCR_write_enable) begin
      ocr_act_nxt_s = OCR_input;
    end else begin
      ocr_act_nxt_s = ocr_act_r;
    end
    tccr_nxt_s  = TCCR_write_enable ? {1'b0, TCCR_input[6:0]} : tccr_r;
    timsk_nxt_s = TIMSK_write_enable ? TIMSK_input : timsk_r;
    // Software clear first, hardware set last so a same-cycle set wins.
    tifr_nxt_s  = TIFR_write_enable ? (tifr_r & ~TIFR_input) : tifr_r;
    tifr_nxt_s[TIFR_TOV] = tifr_nxt_s[TIFR_TOV] | tov_set_s;
    tifr_nxt_s[TIFR_OCF] = tifr_nxt_s[TIFR_OCF] | match_s;
  end

  // Compare output pin next-state for each waveform mode.
  always_comb begin
    oc_nxt_s = oc_r;
    case (mode_s)
      MODE_FAST: begin
        case (com_s)
          COM_CLEAR: begin
            if (cnt_tick_s && at_max_s) oc_nxt_s = 1'b1;
            else if (match_s)           oc_nxt_s = 1'b0;
            else                        oc_nxt_s = oc_r;
          end
          COM_SET: begin
            if (cnt_tick_s && at_max_s) oc_nxt_s = 1'b0;
            else if (match_s)           oc_nxt_s = 1'b1;
            else                        oc_nxt_s = oc_r;
          end
          default: oc_nxt_s = 1'b0;
        endcase
      end
      MODE_PC: begin
        case (com_s)
          COM_CLEAR: begin
            if (match_s) oc_nxt_s = pc_down_s;
            else         oc_nxt_s = oc_r;
          end
          COM_SET: begin
            if (match_s) oc_nxt_s = ~pc_down_s;
            else         oc_nxt_s = oc_r;
          end
          default: oc_nxt_s = 1'b0;
        endcase
      end
      default: begin
        if (foc_s)                 oc_nxt_s = oc_match_action(TCCR_input[TCCR_COM_HI:TCCR_COM_LO], oc_r);
        else if (match_s)          oc_nxt_s = oc_match_action(com_s, oc_r);
        else if (com_s == COM_OFF) oc_nxt_s = 1'b0;
        else                       oc_nxt_s = oc_r;
      end
    endcase
  end

  // Timer state registers.
  always_ff @(posedge sysClock or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_r     <= ZERO_V;
      ocr_buf_r  <= ZERO_V;
      ocr_act_r  <= ZERO_V;
      tccr_r     <= 8'h00;
      timsk_r    <= 8'h00;
      tifr_r     <= 8'h00;
      oc_r       <= 1'b0;
      dir_down_r <= 1'b0;
    end else begin
      tcnt_r     <= tcnt_nxt_s;
      ocr_buf_r  <= ocr_buf_nxt_s;
      ocr_act_r  <= ocr_act_nxt_s;
      tccr_r     <= tccr_nxt_s;
      timsk_r    <= timsk_nxt_s;
      tifr_r     <= tifr_nxt_s;
      oc_r       <= oc_nxt_s;
      dir_down_r <= dir_down_nxt_s;
    end
  end

  assign TCNT_output  = tcnt_r;
  assign OCR_output   = ocr_buf_r;
  assign TCCR_output  = tccr_r;
  assign TIMSK_output = timsk_r;
  assign TIFR_output  = tifr_r;
  assign OC_out       = oc_r;
  assign irq_ovf      = tifr_r[TIFR_TOV] & timsk_r[TIMSK_TOIE];
  assign irq_cmp      = tifr_r[TIFR_OCF] & timsk_r[TIMSK_OCIE];

endmodule

// File: tb/tb_timer_nbit_pwm.sv
// Directed bench for timer_nbit_pwm: an 8-bit instance for the mode tests and
// a 12-bit instance for wide wrap and asynchronous reset.
module tb_timer_nbit_pwm;

  logic        sysClock = 1'b0;
  logic        rst_n = 1'b0, rst12_n = 1'b0;
  logic        T_in = 1'b0, clr = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        we_tcnt = 1'b0, we_ocr = 1'b0, we_tccr = 1'b0, we_timsk = 1'b0, we_tifr = 1'b0;

  logic [7:0]  tcnt8, ocr8, tccr8, timsk8, tifr8;
  logic        oc8, iov8, icm8;
  logic [11:0] tcnt12, ocr12;
  logic [7:0]  tccr12, timsk12, tifr12;
  logic        oc12, iov12, icm12;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;
  sb_t sb_q[$];

  timer_nbit_pwm #(.WIDTH(8), .PRE_W(10)) dut (
    .sysClock(sysClock), .rst_n(rst_n), .T_in(T_in),
    .TCNT_data(din[7:0]), .OCR_input(din[7:0]), .TCCR_input(din[7:0]),
    .TIMSK_input(din[7:0]), .TIFR_input(din[7:0]),
    .TCNT_write_enable(we_tcnt), .OCR_write_enable(we_ocr), .TCCR_write_enable(we_tccr),
    .TIMSK_write_enable(we_timsk), .TIFR_write_enable(we_tifr), .clear_count(clr),
    .TCNT_output(tcnt8), .OCR_output(ocr8), .TCCR_output(tccr8),
    .TIMSK_output(timsk8), .TIFR_output(tifr8),
    .OC_out(oc8), .irq_ovf(iov8), .irq_cmp(icm8)
  );

  timer_nbit_pwm #(.WIDTH(12), .PRE_W(10)) dut12 (
    .sysClock(sysClock), .rst_n(rst12_n), .T_in(T_in),
    .TCNT_data(din[11:0]), .OCR_input(din[11:0]), .TCCR_input(din[7:0]),
    .TIMSK_input(din[7:0]), .TIFR_input(din[7:0]),
    .TCNT_write_enable(we_tcnt), .OCR_write_enable(we_ocr), .TCCR_write_enable(we_tccr),
    .TIMSK_write_enable(we_timsk), .TIFR_write_enable(we_tifr), .clear_count(clr),
    .TCNT_output(tcnt12), .OCR_output(ocr12), .TCCR_output(tccr12),
    .TIMSK_output(timsk12), .TIFR_output(tifr12),
    .OC_out(oc12), .irq_ovf(iov12), .irq_cmp(icm12)
  );

  always #5 sysClock = ~sysClock;

  always @(posedge sysClock) cyc <= cyc + 1;

  task automatic expect_val(input string tag, input logic [63:0] e);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sb_q.push_back(s);
  endtask

  task automatic check_val(input logic [63:0] obs);
    sb_t s;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      s = sb_q.pop_front();
      assert (obs === s.exp) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sysClock);
  endtask

  // sel: 0 TCNT, 1 OCR, 2 TCCR, 3 TIMSK, 4 TIFR; strobe spans one rising edge.
  task automatic wr(input int sel, input logic [15:0] v);
    din      = v;
    we_tcnt  = (sel == 0);
    we_ocr   = (sel == 1);
    we_tccr  = (sel == 2);
    we_timsk = (sel == 3);
    we_tifr  = (sel == 4);
    @(negedge sysClock);
    {we_tcnt, we_ocr, we_tccr, we_timsk, we_tifr} = 5'b00000;
  endtask

  // Wait (bounded) until OC_out equals v; return the cycle stamp.
  task automatic wait_oc(input logic v, output int t);
    int n;
    n = 0;
    while (oc8 !== v && n < 2000) begin
      @(negedge sysClock);
      n++;
    end
    t = cyc;
    total++;
    assert (n < 2000) else begin
      bad++;
      $error("FAIL wait_oc_timeout observed=%0b expected=%0b", oc8, v);
    end
  endtask

  initial begin
    int t0, t1, t2, t3, cnt;

    // Reset state
    step(1);
    expect_val("reset_outputs", 64'h0);
    check_val({tcnt8, ocr8, tccr8, timsk8, tifr8, oc8, iov8, icm8});
    rst_n = 1'b1;
    step(3);
    expect_val("stopped_tcnt", 64'h0);
    check_val(tcnt8);

    // 1: normal mode, /1, overflow from 0xFE
    wr(3, 16'h0001);
    wr(2, 16'h0001);
    wr(0, 16'h00FE);
    expect_val("t1_preload", 64'hFE);
    check_val(tcnt8);
    step(1);
    expect_val("t1_ff_tov", {8'hFF, 1'b0});
    check_val({tcnt8, tifr8[0]});
    step(1);
    expect_val("t1_wrap", {8'h00, 1'b1, 1'b1});
    check_val({tcnt8, tifr8[0], iov8});
    wr(4, 16'h0003);
    expect_val("t1_tifr_clear", {1'b0, 1'b0});
    check_val({tifr8[0], iov8});

    // 2: CTC, /8, OCR=4, toggle on match
    wr(1, 16'h0004);
    expect_val("t2_ocr_read", 64'h04);
    check_val(ocr8);
    wr(2, 16'h001A);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    wait_oc(~oc8, t0);
    wait_oc(~oc8, t1);
    wait_oc(~oc8, t2);
    expect_val("t2_half_period", 64'd40);
    check_val(t1 - t0);
    expect_val("t2_full_period", 64'd80);
    check_val(t2 - t0);
    expect_val("t2_ocf", 64'h1);
    check_val(tifr8[1]);

    // 3: fast PWM, /1, OCR=0x40, non-inverting
    wr(1, 16'h0040);
    wr(2, 16'h0069);
    wait_oc(1'b0, t0);
    wait_oc(1'b1, t0);
    wait_oc(1'b0, t1);
    wait_oc(1'b1, t2);
    expect_val("t3_high", 64'd65);
    check_val(t1 - t0);
    expect_val("t3_low", 64'd191);
    check_val(t2 - t1);
    step(10);
    wr(1, 16'h0080);
    expect_val("t3_ocr_buffer", 64'h80);
    check_val(ocr8);
    wait_oc(1'b0, t1);
    expect_val("t3_high_old_ocr", 64'd65);
    check_val(t1 - t2);
    wait_oc(1'b1, t2);
    wait_oc(1'b0, t3);
    expect_val("t3_high_new_ocr", 64'd129);
    check_val(t3 - t2);

    // 4: phase-correct, /1, OCR=0x80, non-inverting
    wr(1, 16'h0080);
    wr(2, 16'h0061);
    wait_oc(1'b1, t0);
    wait_oc(1'b0, t0);
    wait_oc(1'b1, t0);
    wait_oc(1'b0, t0);
    wait_oc(1'b1, t1);
    wait_oc(1'b0, t2);
    expect_val("t4_low", 64'd254);
    check_val(t1 - t0);
    expect_val("t4_high", 64'd256);
    check_val(t2 - t1);
    wr(1, 16'h0000);
    step(1100);
    cnt = 0;
    repeat (520) begin
      @(negedge sysClock);
      if (oc8) cnt++;
    end
    expect_val("t4_ocr0_high_samples", 64'd0);
    check_val(cnt);
    wr(1, 16'h00FF);
    step(1100);
    cnt = 0;
    repeat (520) begin
      @(negedge sysClock);
      if (!oc8) cnt++;
    end
    expect_val("t4_ocrmax_low_samples", 64'd0);
    check_val(cnt);

    // 5: external rising edge clock, normal mode
    wr(2, 16'h0007);
    wr(1, 16'h0012);
    wr(0, 16'h0010);
    wr(4, 16'h0003);
    T_in = 1'b1;
    step(2);
    expect_val("t5_not_yet", 64'h10);
    check_val(tcnt8);
    step(1);
    expect_val("t5_first_edge", 64'h11);
    check_val(tcnt8);
    step(3);
    expect_val("t5_level_no_count", 64'h11);
    check_val(tcnt8);
    T_in = 1'b0;
    step(4);
    expect_val("t5_fall_no_count", 64'h11);
    check_val(tcnt8);
    T_in = 1'b1;
    step(3);
    expect_val("t5_second_edge", {8'h12, 1'b0});
    check_val({tcnt8, tifr8[1]});
    T_in = 1'b0;
    step(4);
    T_in = 1'b1;
    step(2);
    wr(4, 16'h0002);
    expect_val("t5_set_beats_clear", {8'h13, 1'b1});
    check_val({tcnt8, tifr8[1]});
    wr(4, 16'h0002);
    expect_val("t5_ocf_cleared", 64'h0);
    check_val(tifr8[1]);

    // FOC in normal mode: toggle once, FOC reads 0, no OCF, TCNT kept
    wr(2, 16'h0097);
    expect_val("foc_toggle", {8'h17, 1'b1, 1'b0, 8'h13});
    check_val({tccr8, oc8, tifr8[1], tcnt8});

    // 6: 12-bit instance wrap and asynchronous reset
    rst12_n = 1'b1;
    step(1);
    wr(3, 16'h0001);
    wr(2, 16'h0001);
    wr(0, 16'h0FFE);
    step(2);
    expect_val("t6_wrap12", {12'h000, 1'b1, 1'b1});
    check_val({tcnt12, tifr12[0], iov12});
    step(5);
    #2 rst12_n = 1'b0;
    #1;
    expect_val("t6_async_reset", 64'h0);
    check_val({tcnt12, ocr12, tccr12, timsk12, tifr12, oc12, iov12, icm12});
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
